// File: rtl/main_ram_arbiter_if.sv
// Signal bundle joining the ROM/BSRAM mux (port A), the ESP32 host port (port B)
// and the SDRAM controller command port to the main RAM arbiter.
interface main_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 25
);
  logic [ADDR_W-1:0] a_addr;
  logic              a_rd;
  logic              a_wr;
  logic              a_word;
  logic [15:0]       a_din;
  logic [15:0]       a_dout;

  logic              b_req;
  logic              b_we;
  logic              b_word;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_din;
  logic [15:0]       b_dout;
  logic              b_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_word;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_dout;
  logic              mem_busy;

  modport slave (
    input  a_addr, a_rd, a_wr, a_word, a_din,
    output a_dout,
    input  b_req, b_we, b_word, b_addr, b_din,
    output b_dout, b_ack,
    output mem_addr, mem_din, mem_word, mem_rd, mem_wr,
    input  mem_dout, mem_busy
  );

  modport master (
    output a_addr, a_rd, a_wr, a_word, a_din,
    input  a_dout,
    output b_req, b_we, b_word, b_addr, b_din,
    input  b_dout, b_ack,
    input  mem_addr, mem_din, mem_word, mem_rd, mem_wr,
    output mem_dout, mem_busy
  );
endinterface

// File: rtl/main_ram_arbiter.sv
// Shares the single SDRAM controller port between the SNES core (port A, level
// requests) and the ESP32 save-RAM host port (port B, req/ack), with anti-starvation.
module main_ram_arbiter #(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset_n,
  main_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_a_act;
  logic [ADDR_W-1:0] r_a_addr_prev;
  logic              r_a_pend;
  logic [3:0]        r_starve;

  logic              r_owner_b;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_din;
  logic              r_mem_word;
  logic [15:0]       r_a_dout;
  logic [15:0]       r_b_dout;
  logic              r_b_ack;

  logic              w_a_act;
  logic              w_a_event;
  logic              w_b_pend;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_done;

  assign w_a_act   = bus.a_rd | bus.a_wr;
  assign w_a_event = w_a_act & (~r_a_act | (bus.a_addr != r_a_addr_prev));
  // b_req is still high in the ack cycle; it only counts as a new request after that
  assign w_b_pend  = bus.b_req & ~r_b_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_a_pend && !(w_b_pend && (r_starve == LIMIT))) begin
          w_grant_a   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (w_b_pend) begin
          w_grant_b   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!bus.mem_busy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    if (r_state == S_ISSUE) begin
      bus.mem_rd = ~r_is_wr;
      bus.mem_wr = r_is_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_act       <= 1'b0;
      r_a_addr_prev <= '0;
      r_a_pend      <= 1'b0;
      r_starve      <= '0;
      r_owner_b     <= 1'b0;
      r_is_wr       <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_mem_word    <= 1'b0;
      r_a_dout      <= '0;
      r_b_dout      <= '0;
      r_b_ack       <= 1'b0;
    end else begin
      r_a_act       <= w_a_act;
      r_a_addr_prev <= bus.a_addr;
      r_a_pend      <= w_a_event | (r_a_pend & ~w_grant_a);
      r_b_ack       <= w_done & r_owner_b;

      if (!w_b_pend || w_grant_b) begin
        r_starve <= '0;
      end else if (w_grant_a && (r_starve < LIMIT)) begin
        r_starve <= r_starve + 4'd1;
      end

      // a_wr alone decides direction, so a simultaneous rd+wr becomes a write
      if (w_grant_a) begin
        r_owner_b  <= 1'b0;
        r_is_wr    <= bus.a_wr;
        r_mem_addr <= bus.a_addr;
        r_mem_din  <= bus.a_din;
        r_mem_word <= bus.a_word;
      end else if (w_grant_b) begin
        r_owner_b  <= 1'b1;
        r_is_wr    <= bus.b_we;
        r_mem_addr <= bus.b_addr;
        r_mem_din  <= bus.b_din;
        r_mem_word <= bus.b_word;
      end

      if (w_done && !r_is_wr) begin
        if (r_owner_b) begin
          r_b_dout <= bus.mem_dout;
        end else begin
          r_a_dout <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign bus.mem_word = r_mem_word;
  assign bus.a_dout   = r_a_dout;
  assign bus.b_dout   = r_b_dout;
  assign bus.b_ack    = r_b_ack;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Bench for main_ram_arbiter: directed scenarios plus randomized traffic, all
// compared each cycle against a transaction-level reference model.
module tb_main_ram_arbiter;

  localparam int unsigned AW    = 25;
  localparam int          LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  main_ram_arbiter_if #(.ADDR_W(AW)) bus ();

  main_ram_arbiter #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory responder
  logic [15:0] memarr [int unsigned];
  int          cfg_busy = -1;
  int          rsp_left;
  logic [15:0] rsp_data;

  // observations of the DUT command stream
  int          n_rd, n_wr, n_ack;
  int          rd_cyc[$];
  int          last_wr_cyc;
  logic [AW-1:0] last_rd_addr, last_wr_addr;
  logic [15:0] last_wr_din;
  logic        prev_strobe;

  // reference model: pending flags, a transaction record and cycle arithmetic
  logic          m_prev_act;
  logic [AW-1:0] m_prev_addr;
  logic          m_a_pend;
  int            m_starve;
  logic          m_active;
  int            m_issue_cyc;
  logic          m_owner_b, m_is_wr;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_din, e_a_dout, e_b_dout;
  logic          e_word, e_b_ack;
  logic          m_ev, m_bpend, m_ga, m_gb, m_done, e_rd, e_wr;

  task automatic model_reset();
    m_prev_act = 1'b0; m_prev_addr = '0; m_a_pend = 1'b0; m_starve = 0;
    m_active = 1'b0; m_issue_cyc = 0; m_owner_b = 1'b0; m_is_wr = 1'b0;
    e_addr = '0; e_din = '0; e_a_dout = '0; e_b_dout = '0; e_word = 1'b0; e_b_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      rsp_left     = 0;
      bus.mem_busy = 1'b0;
      bus.mem_dout = '0;
      prev_strobe  = 1'b0;
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_mem_wr", bus.mem_wr, 0);
      chk("rst_b_ack", bus.b_ack, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
    end else begin
      e_rd = m_active && (m_issue_cyc == cyc) && !m_is_wr;
      e_wr = m_active && (m_issue_cyc == cyc) && m_is_wr;
      chk("mem_rd", bus.mem_rd, e_rd);
      chk("mem_wr", bus.mem_wr, e_wr);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_din", bus.mem_din, e_din);
      chk("mem_word", bus.mem_word, e_word);
      chk("a_dout", bus.a_dout, e_a_dout);
      chk("b_dout", bus.b_dout, e_b_dout);
      chk("b_ack", bus.b_ack, e_b_ack);
      chk("strobe_overlap", bus.mem_rd & bus.mem_wr, 0);
      chk("strobe_adjacent", (bus.mem_rd | bus.mem_wr) & prev_strobe, 0);
      prev_strobe = bus.mem_rd | bus.mem_wr;

      // memory side: busy/data for the edge that ends this cycle
      bus.mem_busy = (rsp_left != 0);
      if (rsp_left != 0) rsp_left--;
      bus.mem_dout = bus.mem_busy ? 16'($urandom) : rsp_data;

      if (bus.mem_rd) begin
        n_rd++;
        rd_cyc.push_back(cyc);
        last_rd_addr = bus.mem_addr;
        rsp_data = memarr.exists(32'(bus.mem_addr)) ? memarr[32'(bus.mem_addr)]
                                                    : (16'(bus.mem_addr) ^ 16'h5A5A);
      end
      if (bus.mem_wr) begin
        n_wr++;
        last_wr_cyc  = cyc;
        last_wr_addr = bus.mem_addr;
        last_wr_din  = bus.mem_din;
        memarr[32'(bus.mem_addr)] = bus.mem_din;
        rsp_data = 16'($urandom);
      end
      if (bus.mem_rd || bus.mem_wr)
        rsp_left = (cfg_busy < 0) ? int'($urandom_range(0, 4)) : cfg_busy;
      if (bus.b_ack) n_ack++;

      // advance the model across the coming clock edge
      m_ev    = (bus.a_rd | bus.a_wr) && (!m_prev_act || (bus.a_addr != m_prev_addr));
      m_bpend = bus.b_req && !e_b_ack;
      m_ga = 1'b0; m_gb = 1'b0; m_done = 1'b0;
      if (!m_active) begin
        if (m_a_pend && !(m_bpend && m_starve == LIMIT)) m_ga = 1'b1;
        else if (m_bpend) m_gb = 1'b1;
      end else if (cyc > m_issue_cyc && !bus.mem_busy) begin
        m_done = 1'b1;
      end
      e_b_ack = m_done && m_owner_b;
      if (m_done) begin
        if (!m_is_wr) begin
          if (m_owner_b) e_b_dout = bus.mem_dout;
          else           e_a_dout = bus.mem_dout;
        end
        m_active = 1'b0;
      end
      if (m_ga) begin
        m_active = 1'b1; m_issue_cyc = cyc + 1; m_owner_b = 1'b0; m_is_wr = bus.a_wr;
        e_addr = bus.a_addr; e_din = bus.a_din; e_word = bus.a_word;
      end
      if (m_gb) begin
        m_active = 1'b1; m_issue_cyc = cyc + 1; m_owner_b = 1'b1; m_is_wr = bus.b_we;
        e_addr = bus.b_addr; e_din = bus.b_din; e_word = bus.b_word;
      end
      if (!m_bpend || m_gb) m_starve = 0;
      else if (m_ga && m_starve < LIMIT) m_starve++;
      m_a_pend    = m_ev || (m_a_pend && !m_ga);
      m_prev_act  = bus.a_rd | bus.a_wr;
      m_prev_addr = bus.a_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic b_xact(input logic we, input logic [AW-1:0] addr, input logic [15:0] din);
    bit got;
    got = 1'b0;
    step();
    bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_din = din; bus.b_word = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.b_ack) begin got = 1'b1; break; end
    end
    chk("b_ack_seen", got, 1);
    step();
    bus.b_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, snap_r, snap_w, snap_a, b_rise, cnt;
    bit got, ackseen;

    reset_n = 1'b0;
    bus.a_addr = '0; bus.a_rd = 1'b0; bus.a_wr = 1'b0; bus.a_word = 1'b0; bus.a_din = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_word = 1'b0; bus.b_addr = '0; bus.b_din = '0;
    repeat (3) step();
    chk("reset_a_dout", bus.a_dout, 0);
    chk("reset_b_dout", bus.b_dout, 0);
    chk("reset_mem_din", bus.mem_din, 0);
    chk("reset_mem_word", bus.mem_word, 0);
    reset_n = 1'b1;
    repeat (2) step();

    // single A read, 5 busy cycles
    memarr[32'h100] = 16'hBEEF;
    cfg_busy = 5;
    snap_r = n_rd;
    bus.a_addr = AW'(32'h100); bus.a_rd = 1'b1; e = cyc;
    until_cyc(e + 8);
    chk("t1_a_dout_early", bus.a_dout, 0);
    until_cyc(e + 9);
    chk("t1_a_dout", bus.a_dout, 16'hBEEF);
    until_cyc(e + 20);
    chk("t1_rd_pulses", n_rd - snap_r, 1);
    chk("t1_mem_addr", last_rd_addr, 32'h100);

    // address change re-trigger with a_rd held
    step(); bus.a_rd = 1'b0; cfg_busy = 2;
    repeat (3) step();
    snap_r = n_rd;
    bus.a_rd = 1'b1; bus.a_addr = AW'(32'h10);
    repeat (20) step(); bus.a_addr = AW'(32'h12);
    repeat (20) step(); bus.a_addr = AW'(32'h14);
    repeat (40) step();
    chk("t2_rd_pulses", n_rd - snap_r, 3);
    chk("t2_last_addr", last_rd_addr, 32'h14);
    bus.a_rd = 1'b0;

    // B write then read back
    repeat (3) step();
    snap_w = n_wr; snap_a = n_ack;
    b_xact(1'b1, AW'(32'h1000000), 16'h1234);
    chk("t3_wr_pulses", n_wr - snap_w, 1);
    chk("t3_wr_din", last_wr_din, 16'h1234);
    chk("t3_wr_addr", last_wr_addr, 32'h1000000);
    chk("t3_ack_count_wr", n_ack - snap_a, 1);
    b_xact(1'b0, AW'(32'h1000000), 16'h0000);
    chk("t3_b_dout", bus.b_dout, 16'h1234);
    chk("t3_ack_count_rd", n_ack - snap_a, 2);

    // starvation: continuous A traffic while B waits
    cfg_busy = 1; bus.a_rd = 1'b1; bus.a_wr = 1'b0; got = 1'b0; b_rise = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      bus.a_addr = AW'(32'h200 + 2 * i);
      if (i == 10) begin
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = AW'(32'h1F0000); bus.b_din = 16'h5555;
        b_rise = cyc;
      end
      @(negedge clk);
      if (bus.b_req && bus.b_ack) got = 1'b1;
    end
    chk("t4_b_ack_seen", got, 1);
    step(); bus.b_req = 1'b0; bus.a_rd = 1'b0;
    cnt = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] > b_rise && rd_cyc[k] < last_wr_cyc) cnt++;
    chk("t4_a_grants_before_b", cnt, LIMIT);
    chk("t4_b_addr", last_wr_addr, 32'h1F0000);
    repeat (3) step();
    chk("t4_starve_cnt", dut.r_starve, 0);

    // read and write requested together
    repeat (5) step();
    snap_r = n_rd; snap_w = n_wr;
    bus.a_addr = AW'(32'h300); bus.a_din = 16'hA5A5; bus.a_word = 1'b1;
    bus.a_rd = 1'b1; bus.a_wr = 1'b1;
    repeat (15) step();
    chk("t5_rd_pulses", n_rd - snap_r, 0);
    chk("t5_wr_pulses", n_wr - snap_w, 1);
    chk("t5_wr_din", last_wr_din, 16'hA5A5);
    bus.a_rd = 1'b0; bus.a_wr = 1'b0;

    // reset during WAIT of a B read
    cfg_busy = 10;
    repeat (3) step();
    snap_a = n_ack;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = AW'(32'h1000000);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_rd) begin got = 1'b1; break; end
    end
    chk("t6_strobe_seen", got, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_mem_rd", bus.mem_rd, 0);
    chk("t6_mem_wr", bus.mem_wr, 0);
    chk("t6_mem_addr", bus.mem_addr, 0);
    chk("t6_mem_din", bus.mem_din, 0);
    chk("t6_a_dout", bus.a_dout, 0);
    chk("t6_b_dout", bus.b_dout, 0);
    chk("t6_b_ack", bus.b_ack, 0);
    bus.b_req = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("t6_no_ack", n_ack - snap_a, 0);
    cfg_busy = 0;
    bus.a_addr = AW'(32'h100); bus.a_rd = 1'b1; bus.a_wr = 1'b0;
    repeat (8) step();
    chk("t6_resume_a_dout", bus.a_dout, 16'hBEEF);
    bus.a_rd = 1'b0;

    // randomized traffic
    cfg_busy = -1; ackseen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) begin
        bus.a_rd = 1'($urandom_range(0, 1));
        bus.a_wr = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 5) == 0) bus.a_addr = AW'($urandom_range(0, 15) * 2);
      if ($urandom_range(0, 3) == 0) begin
        bus.a_din = 16'($urandom); bus.a_word = 1'($urandom_range(0, 1));
      end
      if (bus.b_req && ackseen) begin
        ackseen = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          bus.b_we = 1'($urandom_range(0, 1)); bus.b_addr = AW'($urandom_range(0, 7) * 2);
          bus.b_din = 16'($urandom); bus.b_word = 1'($urandom_range(0, 1));
        end else begin
          bus.b_req = 1'b0;
        end
      end else if (!bus.b_req && $urandom_range(0, 5) == 0) begin
        bus.b_req = 1'b1;
        bus.b_we = 1'($urandom_range(0, 1)); bus.b_addr = AW'($urandom_range(0, 7) * 2);
        bus.b_din = 16'($urandom); bus.b_word = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.b_ack) ackseen = 1'b1;
    end
    step(); bus.b_req = 1'b0; bus.a_rd = 1'b0; bus.a_wr = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
